// File: rtl/defines_pkg.sv
// Shared sizing for the MVM frame driver: matrix dimension and frame length rule.
package defines_pkg;

  localparam int NROWS_A = 4;

  // A matrix (n*n bytes), then X vector (n bytes), then B vector (n bytes)
  function automatic int frame_len(input int n);
    return n * n + 2 * n;
  endfunction

  localparam int FRAME_LEN = frame_len(NROWS_A);

endpackage

// File: rtl/memory.sv
// Simple single-port-write, async-read byte store used as the frame buffer.
module memory #(
  parameter int WIDTH   = 8,
  parameter int SIZE    = 24,
  parameter int LOGSIZE = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LOGSIZE-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [LOGSIZE-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mvm_frame_driver.sv
// Buffers one MVM frame, streams it to the MVM over valid/ready and collects
// the NROWS_A results it returns.
//   state  | meaning
//   IDLE   | waiting for load bytes or start with a full frame
//   LOAD   | accepting frame bytes into the buffer
//   XFER   | streaming frame bytes out and capturing results
//   DONE   | one-cycle completion pulse, frame buffer released
module mvm_frame_driver
  import defines_pkg::frame_len;
#(
  parameter int NROWS_A   = defines_pkg::NROWS_A,
  parameter int FRAME_LEN = frame_len(NROWS_A)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  input  logic [7:0]                 ld_data,
  output logic                       ld_ready,
  input  logic                       start,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  input  logic                       rx_valid,
  input  logic [15:0]                rx_data,
  input  logic                       rx_overflow,
  output logic                       rx_ready,
  input  logic [$clog2(NROWS_A)-1:0] res_addr,
  output logic [15:0]                res_data,
  output logic                       ovf_any,
  output logic                       done,
  output logic                       busy
);

  localparam int AW  = $clog2(FRAME_LEN);
  localparam int CW  = $clog2(FRAME_LEN + 1);
  localparam int RW  = $clog2(NROWS_A + 1);
  localparam int RAW = (NROWS_A > 1) ? $clog2(NROWS_A) : 1;
  localparam logic [CW-1:0] LEN_C  = CW'(FRAME_LEN);
  localparam logic [AW-1:0] LAST_C = AW'(FRAME_LEN - 1);
  localparam logic [RW-1:0] ROWS_C = RW'(NROWS_A);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_XFER, S_DONE} state_t;

  state_t          state, state_nxt;
  logic            rdy_en;
  logic            frame_full;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   tx_cnt;
  logic [RW-1:0]   rx_cnt;
  logic [AW-1:0]   raddr;
  logic [7:0]      rd_byte;
  logic [15:0]     results [NROWS_A];

  logic ld_fire, ld_last, xfer_go, tx_fire, rx_fire;

  assign ld_ready = rdy_en && !frame_full && (state == S_IDLE || state == S_LOAD);
  assign ld_fire  = ld_valid && ld_ready;
  assign ld_last  = ld_fire && (wr_ptr == LAST_C);
  assign xfer_go  = (state == S_IDLE) && start && frame_full;
  assign tx_fire  = tx_valid && tx_ready;
  assign rx_ready = (state == S_XFER) && (rx_cnt < ROWS_C);
  assign rx_fire  = rx_valid && rx_ready;
  assign busy     = (state == S_LOAD) || (state == S_XFER);
  assign done     = (state == S_DONE);
  assign res_data = results[res_addr];

  // Read address is 0 outside XFER so the entry cycle can prefetch byte 0
  assign raddr = (state == S_XFER && rd_ptr < LEN_C) ? rd_ptr[AW-1:0] : '0;

  memory #(
    .WIDTH   (8),
    .SIZE    (FRAME_LEN),
    .LOGSIZE (AW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (wr_ptr),
    .wdata (ld_data),
    .raddr (raddr),
    .rdata (rd_byte)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (xfer_go)                  state_nxt = S_XFER;
        else if (ld_fire && !ld_last) state_nxt = S_LOAD;
      end
      S_LOAD: if (ld_last) state_nxt = S_IDLE;
      S_XFER: if (tx_cnt == LEN_C && rx_cnt == ROWS_C) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rdy_en     <= 1'b0;
      frame_full <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      ovf_any    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;

      if (ld_fire) wr_ptr <= ld_last ? '0 : wr_ptr + 1'b1;
      if (ld_last) frame_full <= 1'b1;
      if (state == S_DONE) frame_full <= 1'b0;

      if (xfer_go) begin
        tx_cnt   <= '0;
        rx_cnt   <= '0;
        ovf_any  <= 1'b0;
        tx_data  <= rd_byte;
        tx_valid <= 1'b1;
        rd_ptr   <= CW'(1);
      end else if (state == S_XFER) begin
        // Output register refills on the same edge it drains: no bubbles
        if (tx_fire) begin
          tx_cnt <= tx_cnt + 1'b1;
          if (rd_ptr < LEN_C) begin
            tx_data <= rd_byte;
            rd_ptr  <= rd_ptr + 1'b1;
          end else begin
            tx_valid <= 1'b0;
          end
        end
        if (rx_fire) begin
          rx_cnt  <= rx_cnt + 1'b1;
          ovf_any <= ovf_any | rx_overflow;
        end
      end
    end
  end

  // Result store is left unreset; contents are meaningful only after a frame
  always_ff @(posedge clk) begin
    if (rx_fire) results[rx_cnt[RAW-1:0]] <= rx_data;
  end

endmodule
